// File: rtl/text_memory_loader_pkg.sv
// Shared definitions for the text memory loader: FSM states and text-segment
// word base.
package text_memory_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

  localparam logic [31:0] TEXT_BEGIN = 32'h0000_0000;
  // Word address of the first instruction, relative to the text memory port.
  localparam int unsigned TEXT_BEGIN_WORD = TEXT_BEGIN >> 2;

  // An image of exactly 2**addr_width words still fits, so only larger ones are rejected.
  function automatic logic is_oversize(input logic [31:0] count, input int unsigned addr_width);
    logic [32:0] limit;
    limit = 33'd1 << addr_width;
    return {1'b0, count} > limit;
  endfunction

endpackage

// File: rtl/text_memory_loader_if.sv
// Byte stream in and text memory write port out, as seen by the loader.
interface text_memory_loader_if #(
  parameter int ADDR_WIDTH = 14
);
  logic [7:0]            byte_data;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  mem_write_enable;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_write_data;

  modport master (
    output byte_data, byte_valid,
    input  byte_ready, mem_write_enable, mem_address, mem_write_data
  );

  modport slave (
    input  byte_data, byte_valid,
    output byte_ready, mem_write_enable, mem_address, mem_write_data
  );
endinterface

// File: rtl/text_memory_loader_byte_assembler.sv
// Collects four bytes little-endian into a 32-bit word; shared by the header
// and payload phases of the loader.
module text_memory_loader_byte_assembler
  import text_memory_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_complete_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  index_q, index_d;

  // Shifting in from the top leaves the first byte in bits 7:0 after four bytes.
  always_comb begin
    word_d  = word_q;
    index_d = index_q;
    if (clear_i) begin
      word_d  = '0;
      index_d = '0;
    end else if (shift_i) begin
      word_d  = {byte_i, word_q[31:8]};
      index_d = index_q + 2'd1;
    end
  end

  assign word_o          = {byte_i, word_q[31:8]};
  assign word_complete_o = shift_i && !clear_i && (index_q == 2'd3);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_q  <= '0;
      index_q <= '0;
    end else begin
      word_q  <= word_d;
      index_q <= index_d;
    end
  end

endmodule

// File: rtl/text_memory_loader.sv
// Streams a length-prefixed program image into text memory while holding the
// core in reset; reports completion, timeouts and oversize images.
module text_memory_loader
  import text_memory_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 14,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  text_memory_loader_if.slave bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                error
);

  localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  loader_state_e         state_q, state_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_data_q, mem_data_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic        transfer;
  logic        start_load;
  logic [31:0] asm_word;
  logic        asm_complete;

  assign bus.byte_ready = (state_q == ST_LEN) || (state_q == ST_DATA);
  assign transfer       = bus.byte_valid && bus.byte_ready;
  assign start_load     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                    (state_q == ST_ERROR));

  text_memory_loader_byte_assembler u_assembler (
    .clock           (clock),
    .reset           (reset),
    .clear_i         (start_load),
    .shift_i         (transfer),
    .byte_i          (bus.byte_data),
    .word_o          (asm_word),
    .word_complete_o (asm_complete)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    word_idx_d  = word_idx_q;
    timer_d     = timer_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d     = ST_LEN;
          done_d      = 1'b0;
          error_d     = 1'b0;
          word_idx_d  = ADDR_WIDTH'(TEXT_BEGIN_WORD);
          remaining_d = '0;
          timer_d     = '0;
        end
      end
      ST_LEN, ST_DATA: begin
        timer_d = transfer ? '0 : timer_q + TIMER_WIDTH'(1);
        if (!transfer && (timer_q == TIMER_WIDTH'(TIMEOUT_CYCLES - 1))) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
        end else if (asm_complete && (state_q == ST_LEN)) begin
          if (asm_word == 32'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (is_oversize(asm_word, ADDR_WIDTH)) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else begin
            state_d     = ST_DATA;
            remaining_d = asm_word[ADDR_WIDTH:0];
          end
        end else if (asm_complete) begin
          // Write port is registered so the strobe lines up with the WRITE state.
          state_d    = ST_WRITE;
          mem_we_d   = 1'b1;
          mem_addr_d = word_idx_q;
          mem_data_d = asm_word;
        end
      end
      ST_WRITE: begin
        word_idx_d  = word_idx_q + ADDR_WIDTH'(1);
        remaining_d = remaining_q - (ADDR_WIDTH + 1)'(1);
        if (remaining_q == (ADDR_WIDTH + 1)'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    hold_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_WRITE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      word_idx_q  <= '0;
      timer_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      hold_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      word_idx_q  <= word_idx_d;
      timer_q     <= timer_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.mem_write_enable = mem_we_q;
  assign bus.mem_address      = mem_addr_q;
  assign bus.mem_write_data   = mem_data_q;
  assign cpu_hold             = hold_q;
  assign done                 = done_q;
  assign error                = error_q;

endmodule
